// File: rtl/y86_mem_responder_if.sv
// y86_mem_responder_if
//   Request/response bundle between a Y86 processor and its memory model.
//   master : processor side (drives requests, takes responses)
//   slave  : memory responder side
//   Request : req_valid, req_ready, req_ifetch, req_write, req_addr[63:0], req_wdata[63:0]
//   Response: resp_valid, resp_ready, resp_rdata[79:0], resp_err
interface y86_mem_responder_if;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned WDATA_W = 64;
  localparam int unsigned RDATA_W = 80;

  logic               req_valid;
  logic               req_ready;
  logic               req_ifetch;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [WDATA_W-1:0] req_wdata;
  logic               resp_valid;
  logic               resp_ready;
  logic [RDATA_W-1:0] resp_rdata;
  logic               resp_err;

  modport master (
    output req_valid, req_ifetch, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_ifetch, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/y86_mem_responder.sv
// y86_mem_responder
//   Byte-addressable little-endian memory answering Y86 instruction fetches
//   (10 bytes) and data accesses (8 bytes), one outstanding request at a time.
//   Ports:
//     clock   : sole clock, rising edge
//     reset_n : synchronous active-low reset (memory contents are kept)
//     bus     : y86_mem_responder_if.slave request/response bundle
//   Optional feature: define Y86_MEM_WAIT_EN to insert WAIT_CYCLES wait states
//   between acceptance and the response. Without it, acceptance goes straight
//   to RESP and resp_valid rises one edge later.
module y86_mem_responder #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  y86_mem_responder_if.slave   bus
);

  localparam int unsigned AW      = $clog2(MEM_BYTES);
  localparam int unsigned ILEN    = 10;
  localparam int unsigned DLEN    = 8;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned WDATA_W = 64;
  localparam int unsigned RDATA_W = 80;

  // Elaboration-time parameter sanity
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("y86_mem_responder: WAIT_CYCLES must be in 1..15");
  end
  if (MEM_BYTES < ILEN) begin : g_bad_mem
    $error("y86_mem_responder: MEM_BYTES must hold at least one instruction");
  end

`ifdef Y86_MEM_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`else
  typedef enum logic {S_IDLE, S_RESP} state_t;
`endif

  state_t state_q, state_d;

  // Request captured at acceptance
  logic               lat_ifetch_q;
  logic               lat_write_q;
  logic [ADDR_W-1:0]  lat_addr_q;
  logic [WDATA_W-1:0] lat_wdata_q;

`ifdef Y86_MEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  // Registered outputs and their next values
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [RDATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic accept_c;
  logic enter_resp_c;
  logic leave_resp_c;

  logic [7:0] mem [MEM_BYTES];

  // Request being serviced: live inputs while idle, captured copy afterwards
  logic               cur_ifetch_c;
  logic               cur_write_c;
  logic [ADDR_W-1:0]  cur_addr_c;
  logic [WDATA_W-1:0] cur_wdata_c;
  logic [ADDR_W-1:0]  cur_len_c;
  logic               cur_err_c;
  logic [AW-1:0]      base_c;
  logic [RDATA_W-1:0] raw_c;
  logic [RDATA_W-1:0] rdata_c;
  logic               commit_c;

  always_comb begin
    if (state_q == S_IDLE) begin
      cur_ifetch_c = bus.req_ifetch;
      cur_write_c  = bus.req_write & ~bus.req_ifetch;
      cur_addr_c   = bus.req_addr;
      cur_wdata_c  = bus.req_wdata;
    end else begin
      cur_ifetch_c = lat_ifetch_q;
      cur_write_c  = lat_write_q & ~lat_ifetch_q;
      cur_addr_c   = lat_addr_q;
      cur_wdata_c  = lat_wdata_q;
    end
  end

  // Bounds check in full 64-bit unsigned arithmetic so huge addresses never wrap
  always_comb begin
    cur_len_c = cur_ifetch_c ? ADDR_W'(ILEN) : ADDR_W'(DLEN);
    cur_err_c = cur_addr_c > (ADDR_W'(MEM_BYTES) - cur_len_c);
    base_c    = cur_addr_c[AW-1:0];
  end

  // Read path: 10 bytes little-endian; data reads zero the top two bytes
  always_comb begin
    raw_c = '0;
    for (int i = 0; i < int'(ILEN); i++) begin
      raw_c[8*i +: 8] = mem[base_c + AW'(i)];
    end
    rdata_c = '0;
    if (!cur_err_c && !cur_write_c) begin
      if (cur_ifetch_c) rdata_c = raw_c;
      else              rdata_c = {16'h0000, raw_c[63:0]};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    enter_resp_c = 1'b0;
    leave_resp_c = 1'b0;
`ifdef Y86_MEM_WAIT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept_c = 1'b1;
`ifdef Y86_MEM_WAIT_EN
          state_d = S_WAIT;
          cnt_d   = '0;
`else
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
`endif
        end
      end
`ifdef Y86_MEM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      S_RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          state_d      = S_IDLE;
          leave_resp_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
`ifdef Y86_MEM_WAIT_EN
    resp_valid_d = (state_d == S_RESP);
`else
    // Data is captured on the accept edge; valid follows one edge later
    resp_valid_d = (state_q == S_RESP) && (state_d == S_RESP);
`endif
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (enter_resp_c) begin
      resp_rdata_d = rdata_c;
      resp_err_d   = cur_err_c;
    end else if (leave_resp_c) begin
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
    end

    commit_c = enter_resp_c & cur_write_c & ~cur_err_c;
  end

  // State, captured request and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lat_ifetch_q <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef Y86_MEM_WAIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef Y86_MEM_WAIT_EN
      cnt_q        <= cnt_d;
`endif
      if (accept_c) begin
        lat_ifetch_q <= bus.req_ifetch;
        lat_write_q  <= bus.req_write;
        lat_addr_q   <= bus.req_addr;
        lat_wdata_q  <= bus.req_wdata;
      end
    end
  end

  // Storage: never cleared; a write still pending when reset hits is dropped
  always_ff @(posedge clock) begin
    if (reset_n && commit_c) begin
      for (int i = 0; i < int'(DLEN); i++) begin
        mem[base_c + AW'(i)] <= cur_wdata_c[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_y86_mem_responder.sv
// tb_y86_mem_responder
//   Randomized bench for y86_mem_responder with a byte-array reference model.
//   Honors Y86_MEM_WAIT_EN for the expected response latency.
module tb_y86_mem_responder;

  localparam int unsigned MEM_BYTES   = 1024;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef Y86_MEM_WAIT_EN
  localparam int EXP_LAT = WAIT_CYCLES + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  y86_mem_responder_if bus();

  y86_mem_responder #(
    .MEM_BYTES  (MEM_BYTES),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [7:0] ref_mem [MEM_BYTES];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference read: what a request should return given the model contents
  function automatic logic [79:0] model_read(input bit ifetch, input bit write,
                                             input logic [63:0] addr, output bit err);
    logic [79:0] r;
    logic [63:0] len;
    len = ifetch ? 64'd10 : 64'd8;
    err = addr > (64'(MEM_BYTES) - len);
    r   = '0;
    if (!err && (ifetch || !write)) begin
      for (int i = 0; i < int'(len); i++) r[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
    end
    return r;
  endfunction

  task automatic model_write(input logic [63:0] addr, input logic [63:0] wdata);
    for (int i = 0; i < 8; i++) ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
  endtask

  // Present a request and return just after its accepting edge; scramble inputs afterwards
  task automatic accept_req(input bit ifetch, input bit write,
                            input logic [63:0] addr, input logic [63:0] wdata);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq("req_ready_idle", 80'(bus.req_ready), 80'd1);
    bus.req_valid  = 1'b1;
    bus.req_ifetch = ifetch;
    bus.req_write  = write;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    step();
    bus.req_valid  = 1'b0;
    bus.req_ifetch = 1'($urandom);
    bus.req_write  = 1'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
  endtask

  task automatic finish_resp(input logic [79:0] exp_rdata, input bit exp_err,
                             input int stall, output logic [79:0] obs, output bit obs_err);
    int lat;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check_eq("latency", 80'(lat), 80'(EXP_LAT));
    check_eq("resp_rdata", bus.resp_rdata, exp_rdata);
    check_eq("resp_err", 80'(bus.resp_err), 80'(exp_err));
    check_eq("req_ready_busy", 80'(bus.req_ready), 80'd0);
    obs     = bus.resp_rdata;
    obs_err = bus.resp_err;
    for (int s = 0; s < stall; s++) begin
      step();
      check_eq("stall_valid", 80'(bus.resp_valid), 80'd1);
      check_eq("stall_rdata", bus.resp_rdata, exp_rdata);
      check_eq("stall_ready", 80'(bus.req_ready), 80'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check_eq("post_valid", 80'(bus.resp_valid), 80'd0);
    check_eq("post_ready", 80'(bus.req_ready), 80'd1);
  endtask

  task automatic do_req(input bit ifetch, input bit write, input logic [63:0] addr,
                        input logic [63:0] wdata, input int stall,
                        output logic [79:0] obs, output bit obs_err);
    logic [79:0] exp;
    bit err;
    exp = model_read(ifetch, write, addr, err);
    accept_req(ifetch, write, addr, wdata);
    finish_resp(exp, err, stall, obs, obs_err);
    if (write && !ifetch && !err) model_write(addr, wdata);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    check_eq("rst_valid", 80'(bus.resp_valid), 80'd0);
    check_eq("rst_err", 80'(bus.resp_err), 80'd0);
    check_eq("rst_rdata", bus.resp_rdata, 80'd0);
    check_eq("rst_ready", 80'(bus.req_ready), 80'd0);
    reset_n = 1'b1;
    step();
    check_eq("rst_ready_after", 80'(bus.req_ready), 80'd1);
  endtask

  initial begin
    logic [79:0] obs;
    logic [79:0] prior;
    bit oerr, perr;
    int n;

    bus.req_valid  = 1'b0;
    bus.req_ifetch = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) step();
    apply_reset();

    // Fill the whole memory so every later read has a defined expectation
    for (int j = 0; j < int'(MEM_BYTES) / 8; j++) begin
      do_req(1'b0, 1'b1, 64'(8 * j), {$urandom, $urandom}, 0, obs, oerr);
    end

    // Write then read back the same bytes
    do_req(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 0, obs, oerr);
    check_eq("wr_rdata_zero", obs, 80'd0);
    do_req(1'b0, 1'b0, 64'h10, 64'h0, 0, obs, oerr);
    check_eq("rd_0x10", obs, 80'h00001122334455667788);
    check_eq("rd_0x10_err", 80'(oerr), 80'd0);

    // Fetch boundary
    do_req(1'b1, 1'b0, 64'(MEM_BYTES - 10), 64'h0, 0, obs, oerr);
    check_eq("ifetch_last_err", 80'(oerr), 80'd0);
    do_req(1'b1, 1'b0, 64'(MEM_BYTES - 9), 64'h0, 0, obs, oerr);
    check_eq("ifetch_over_err", 80'(oerr), 80'd1);
    check_eq("ifetch_over_rdata", obs, 80'd0);

    // Huge address must not wrap into memory
    do_req(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 0, obs, oerr);
    check_eq("wrap_wr_err", 80'(oerr), 80'd1);
    do_req(1'b0, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 0, obs, oerr);
    do_req(1'b0, 1'b0, 64'h0, 64'h0, 0, obs, oerr);

    // Long stall on the response
    do_req(1'b0, 1'b0, 64'h10, 64'h0, 5, obs, oerr);

    // Reset during a write that has not yet reached the response
    prior = model_read(1'b0, 1'b0, 64'h20, perr);
    accept_req(1'b0, 1'b1, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA);
`ifndef Y86_MEM_WAIT_EN
    // Without wait states the accept edge already commits the write
    model_write(64'h20, 64'hAAAA_AAAA_AAAA_AAAA);
    prior = model_read(1'b0, 1'b0, 64'h20, perr);
`endif
    reset_n = 1'b0;
    step();
    check_eq("rst_wait_valid", 80'(bus.resp_valid), 80'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("rst_wait_no_resp", 80'(bus.resp_valid), 80'd0);
    end
    do_req(1'b0, 1'b0, 64'h20, 64'h0, 0, obs, oerr);
    check_eq("rst_wait_prior", obs, prior);

    // Reset while the response is being presented
    accept_req(1'b1, 1'b0, 64'h40, 64'h0);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("resp_reached", 80'(bus.resp_valid), 80'd1);
    apply_reset();

    // Randomized mix of fetches, reads and writes including boundary addresses
    for (int t = 0; t < 80; t++) begin
      int kind, sel, len;
      bit ifetch, write;
      logic [63:0] addr;
      kind   = int'($urandom_range(0, 2));
      ifetch = (kind == 0);
      write  = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      len    = ifetch ? 10 : 8;
      sel    = int'($urandom_range(0, 9));
      case (sel)
        0:       addr = 64'(int'(MEM_BYTES) - len);
        1:       addr = 64'(int'(MEM_BYTES) - len + 1);
        2:       addr = {$urandom, $urandom};
        3:       addr = 64'(MEM_BYTES) + 64'($urandom_range(0, 100));
        default: addr = 64'($urandom_range(0, MEM_BYTES - 10));
      endcase
      do_req(ifetch, write, addr, {$urandom, $urandom}, int'($urandom_range(0, 3)), obs, oerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
